vote_tally_n: RTL and testbench

//  Parametrised successor to the 4-candidate electronic voting machine.

---
 rtl/vote_tally_n.sv | 208 ++++++++++++++++++++
 tb/tb_vote_tally_n.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vote_tally_n.sv
// N-candidate voting machine: saturating tallies, spoilt count,
// ballot timeout and a sequential winner/tie scan on close.
module vote_tally_n #(
  parameter int N_CAND  = 8,
  parameter int CNT_W   = 12,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Power,
  input  logic              Clear,
  input  logic              Ballot,
  input  logic              Total,
  input  logic              Close,
  input  logic              Result,
  input  logic [N_CAND-1:0] IN,
  output logic [CNT_W-1:0]  out,
  output logic              armed,
  output logic              closed,
  output logic              tie
);

  localparam int SW = $clog2(N_CAND);
  localparam int RW = $clog2(N_CAND + 2);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] MAXV = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_WAIT, S_SCAN, S_CLOSED
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       btn_q;
  logic [CNT_W-1:0] tally_q [N_CAND];
  logic [CNT_W-1:0] tally_d [N_CAND];
  logic [CNT_W-1:0] spoilt_q, spoilt_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] disp_q, disp_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [SW-1:0]    win_q, win_d;
  logic [SW-1:0]    scan_q, scan_d;
  logic [RW-1:0]    res_q, res_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             tie_q, tie_d;

  logic [4:0]       btn, edg;
  logic             e_clr, e_cls, e_tot, e_bal, e_res;
  logic [CNT_W-1:0] cur;
  logic [RW-1:0]    nidx;

  assign btn   = {Clear, Close, Total, Ballot, Result};
  assign edg   = btn & ~btn_q & {5{Power}};
  assign e_clr = edg[4];
  assign e_cls = edg[3];
  assign e_tot = edg[2];
  assign e_bal = edg[1];
  assign e_res = edg[0];
  assign cur   = tally_q[scan_q];
  assign nidx  = (res_q == RW'(N_CAND + 1)) ? '0
               : res_q + RW'(1);

  function automatic logic [CNT_W-1:0] sat(
    input logic [CNT_W-1:0] x
  );
    return (x == MAXV) ? x : x + CNT_W'(1);
  endfunction

  always_comb begin
    state_d  = state_q;
    tally_d  = tally_q;
    spoilt_d = spoilt_q;
    total_d  = total_q;
    disp_d   = disp_q;
    max_d    = max_q;
    win_d    = win_q;
    scan_d   = scan_q;
    res_d    = res_q;
    timer_d  = timer_q;
    tie_d    = tie_q;
    if (Power) begin
      unique case (state_q)
        S_IDLE: begin
          if (e_clr) begin
            for (int i = 0; i < N_CAND; i++)
              tally_d[i] = '0;
            spoilt_d = '0;
            total_d  = '0;
            disp_d   = '0;
          end else if (e_cls) begin
            state_d = S_SCAN;
            scan_d  = '0;
          end else if (e_tot) begin
            disp_d = total_q;
          end else if (e_bal) begin
            state_d = S_ARMED;
            timer_d = '0;
            disp_d  = '0;
          end
        end
        S_ARMED: begin
          if (e_cls) begin
            state_d = S_SCAN;
            scan_d  = '0;
          end else if (IN == '0) begin
            if (timer_q == TW'(TIMEOUT - 1))
              state_d = S_IDLE;
            else
              timer_d = timer_q + TW'(1);
          end else if ($onehot(IN)) begin
            for (int i = 0; i < N_CAND; i++)
              if (IN[i]) tally_d[i] = sat(tally_q[i]);
            total_d = sat(total_q);
            state_d = S_WAIT;
          end else begin
            spoilt_d = sat(spoilt_q);
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (IN == '0) state_d = S_IDLE;
        end
        S_SCAN: begin
          // lowest index keeps the win; later equal max flags a tie
          if (scan_q == '0) begin
            max_d = cur;
            win_d = '0;
            tie_d = 1'b0;
          end else if (cur > max_q) begin
            max_d = cur;
            win_d = scan_q;
            tie_d = 1'b0;
          end else if (cur == max_q) begin
            tie_d = 1'b1;
          end
          if (scan_q == SW'(N_CAND - 1)) begin
            state_d = S_CLOSED;
            res_d   = '0;
            disp_d  = tally_q[0];
          end else begin
            scan_d = scan_q + SW'(1);
          end
        end
        S_CLOSED: begin
          if (e_clr) begin
            for (int i = 0; i < N_CAND; i++)
              tally_d[i] = '0;
            spoilt_d = '0;
            total_d  = '0;
            disp_d   = '0;
            max_d    = '0;
            win_d    = '0;
            res_d    = '0;
            tie_d    = 1'b0;
            state_d  = S_IDLE;
          end else if (e_tot) begin
            disp_d = total_q;
          end else if (e_res) begin
            res_d = nidx;
            if (nidx < RW'(N_CAND))
              disp_d = tally_q[nidx[SW-1:0]];
            else if (nidx == RW'(N_CAND))
              disp_d = spoilt_q;
            else
              disp_d = CNT_W'(win_q);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      btn_q    <= '0;
      for (int i = 0; i < N_CAND; i++)
        tally_q[i] <= '0;
      spoilt_q <= '0;
      total_q  <= '0;
      disp_q   <= '0;
      max_q    <= '0;
      win_q    <= '0;
      scan_q   <= '0;
      res_q    <= '0;
      timer_q  <= '0;
      tie_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      btn_q    <= btn;
      tally_q  <= tally_d;
      spoilt_q <= spoilt_d;
      total_q  <= total_d;
      disp_q   <= disp_d;
      max_q    <= max_d;
      win_q    <= win_d;
      scan_q   <= scan_d;
      res_q    <= res_d;
      timer_q  <= timer_d;
      tie_q    <= tie_d;
    end
  end

  assign out    = Power ? disp_q : '0;
  assign armed  = (state_q == S_ARMED);
  assign closed = (state_q == S_CLOSED);
  assign tie    = closed & tie_q;

endmodule

// File: tb/tb_vote_tally_n.sv
// Bench for vote_tally_n: vector tables, corner sequences and
// randomized ballots against a counting reference model.
module tb_vote_tally_n;

  localparam int N  = 4;
  localparam int CW = 4;
  localparam int TO = 16;
  localparam int MX = (1 << CW) - 1;

  localparam int B_CLR = 0;
  localparam int B_CLS = 1;
  localparam int B_TOT = 2;
  localparam int B_BAL = 3;
  localparam int B_RES = 4;

  logic          clk = 0;
  logic          rst = 1;
  logic          Power = 0;
  logic          Clear = 0;
  logic          Ballot = 0;
  logic          Total = 0;
  logic          Close = 0;
  logic          Result = 0;
  logic [N-1:0]  IN = '0;
  logic [CW-1:0] out;
  logic          armed, closed, tie;

  vote_tally_n #(.N_CAND(N), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .Power(Power),
    .Clear(Clear), .Ballot(Ballot), .Total(Total),
    .Close(Close), .Result(Result), .IN(IN),
    .out(out), .armed(armed), .closed(closed), .tie(tie)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int m_tally [N];
  int m_spoilt, m_total;

  typedef struct {
    logic [N-1:0] key;
    int           exp_total;
  } vec_t;

  vec_t tab [5];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic press(input int b);
    case (b)
      B_CLR: Clear = 1;
      B_CLS: Close = 1;
      B_TOT: Total = 1;
      B_BAL: Ballot = 1;
      default: Result = 1;
    endcase
    tick;
    Clear = 0; Close = 0; Total = 0;
    Ballot = 0; Result = 0;
    tick;
  endtask

  function automatic int satp(input int x);
    return (x >= MX) ? MX : x + 1;
  endfunction

  task automatic m_clear;
    for (int i = 0; i < N; i++) m_tally[i] = 0;
    m_spoilt = 0;
    m_total  = 0;
  endtask

  task automatic vote(input logic [N-1:0] key);
    press(B_BAL);
    IN = key;
    tick;
    IN = '0;
    tick;
    if (key != 0) begin
      if ($countones(key) == 1) begin
        for (int i = 0; i < N; i++)
          if (key[i]) m_tally[i] = satp(m_tally[i]);
        m_total = satp(m_total);
      end else begin
        m_spoilt = satp(m_spoilt);
      end
    end
  endtask

  task automatic close_and_check(input string tag);
    int n, mx, win, cnt, exp_v;
    mx = -1; win = 0; cnt = 0;
    for (int i = 0; i < N; i++)
      if (m_tally[i] > mx) begin mx = m_tally[i]; win = i; end
    for (int i = 0; i < N; i++)
      if (m_tally[i] == mx) cnt++;
    Close = 1;
    tick;
    Close = 0;
    n = 0;
    while (!closed && n < 100) begin tick; n++; end
    chk({tag, " scan_len"}, n, N);
    chk({tag, " closed"}, int'(closed), 1);
    chk({tag, " out0"}, int'(out), m_tally[0]);
    chk({tag, " tie"}, int'(tie), (cnt >= 2) ? 1 : 0);
    for (int k = 1; k <= N + 2; k++) begin
      press(B_RES);
      if (k < N) exp_v = m_tally[k];
      else if (k == N) exp_v = m_spoilt;
      else if (k == N + 1) exp_v = win;
      else exp_v = m_tally[0];
      chk($sformatf("%s res%0d", tag, k), int'(out), exp_v);
    end
    press(B_TOT);
    chk({tag, " total"}, int'(out), m_total);
    press(B_CLR);
    m_clear();
    chk({tag, " clr_closed"}, int'(closed), 0);
    chk({tag, " clr_out"}, int'(out), 0);
  endtask

  initial begin
    tab[0] = '{4'b0001, 1};
    tab[1] = '{4'b0010, 2};
    tab[2] = '{4'b0001, 3};
    tab[3] = '{4'b0101, 0};
    tab[4] = '{4'b1111, 0};
    m_clear();

    tick; tick;
    chk("rst out", int'(out), 0);
    chk("rst armed", int'(armed), 0);
    chk("rst closed", int'(closed), 0);
    chk("rst tie", int'(tie), 0);
    rst = 0;
    Power = 1;
    tick;

    for (int i = 0; i < 3; i++) begin
      vote(tab[i].key);
      press(B_TOT);
      chk($sformatf("t1 total%0d", i), int'(out), tab[i].exp_total);
    end
    close_and_check("t1");

    for (int i = 3; i < 5; i++) begin
      vote(tab[i].key);
      press(B_TOT);
      chk($sformatf("t2 total%0d", i), int'(out), tab[i].exp_total);
    end
    close_and_check("t2");

    press(B_BAL);
    for (int i = 0; i < TO - 2; i++) tick;
    chk("t3 still_armed", int'(armed), 1);
    tick;
    chk("t3 timeout", int'(armed), 0);
    IN = 4'b0001; tick; IN = '0; tick;
    press(B_TOT);
    chk("t3 no_count", int'(out), 0);

    press(B_BAL);
    IN = 4'b0001;
    for (int i = 0; i < 20; i++) tick;
    IN = 4'b0010; tick; tick; tick;
    IN = '0; tick;
    m_tally[0] = 1; m_total = 1;
    IN = 4'b0010; tick; IN = '0; tick;
    press(B_TOT);
    chk("t4 total", int'(out), 1);

    Power = 0;
    tick;
    chk("t5 blank", int'(out), 0);
    press(B_BAL);
    press(B_CLR);
    press(B_CLS);
    chk("t5 off_out", int'(out), 0);
    Power = 1;
    tick;
    chk("t5 no_arm", int'(armed), 0);
    press(B_TOT);
    chk("t5 total", int'(out), m_total);
    close_and_check("t4t5");

    for (int v = 0; v < 30; v++) begin
      logic [N-1:0] k;
      if ($urandom_range(0, 2) != 0)
        k = N'(1) << $urandom_range(0, N - 1);
      else
        k = N'($urandom_range(0, MX));
      vote(k);
    end
    press(B_TOT);
    chk("rnd total", int'(out), m_total);
    close_and_check("rnd");

    for (int v = 0; v < MX + 2; v++) vote(4'b0001);
    press(B_TOT);
    chk("t6 sat_total", int'(out), MX);
    Close = 1;
    tick;
    Close = 0;
    tick;
    #2 rst = 1;
    #1;
    chk("t6 async_out", int'(out), 0);
    chk("t6 async_closed", int'(closed), 0);
    #1 rst = 0;
    m_clear();
    tick;
    press(B_TOT);
    chk("t6 post_rst", int'(out), 0);
    vote(4'b0010);
    close_and_check("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
